// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, state and datapath-select encodings for multicycle_ctrl
package ctrl_pkg;
  localparam int WAIT_W = 8;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LR   = 4'd3,
    OP_SR   = 4'd4,
    OP_BNEQ = 4'd5,
    OP_LI   = 4'd6,
    OP_SUB  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JMP  = 4'd9
  } opcode_e;
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd2,
    S_R_EXE     = 4'd3,
    S_LR_ADDR   = 4'd4,
    S_SR_ADDR   = 4'd5,
    S_BRANCH    = 4'd6,
    S_JUMP      = 4'd7,
    S_MEM_READ  = 4'd9,
    S_MEM_WB    = 4'd10,
    S_MEM_STORE = 4'd11,
    S_ALU_WB    = 4'd12,
    S_ERROR     = 4'd13
  } state_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_PASS_B = 2'd2} alu_op_e;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALU_BUF = 2'd1, PC_JUMP = 2'd2, PC_RESET_VEC = 2'd3} pc_src_e;
  typedef enum logic [1:0] {SRC_B_REG = 2'd0, SRC_B_PLUS_1 = 2'd1, SRC_B_IMM = 2'd2} src_b_e;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating data-memory wait counter with timeout compare
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + {{(WAIT_W-1){1'b0}}, cnt_q != '1} : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  // fires on the waiting cycle that brings the count up to MEM_TIMEOUT
  assign timeout = inc && cnt_q == WAIT_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM; define CTRL_MEM_TIMEOUT_EN to enable the memory wait timeout
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WIDTH_OPCODE = 4,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    IR_Write,
  output logic                    MemToReg,
  output logic                    Mem_Read_not_Write,
  output logic                    Mem_Select,
  output logic                    pc_write_enable,
  output logic                    alu_src_a,
  output logic                    RegWrite,
  output logic                    error,
  output logic [1:0]              PC_Source,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              ALUop,
  output logic [3:0]              state_dbg
);
  state_e     state_q, state_d;
  logic [3:0] op;
  logic       take, timeout;
  // nonzero upper opcode bits map to 15, which is undefined
  assign op = (opcode >> 4) == '0 ? opcode[3:0] : 4'hF;
  assign take = (op == OP_BNEQ && !zero) || (op == OP_BEQ && zero);
  assign state_dbg = state_q;
`ifdef CTRL_MEM_TIMEOUT_EN
  logic in_mem;
  assign in_mem = state_q == S_MEM_READ || state_q == S_MEM_STORE;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_mem),
    .inc     (in_mem && !mem_ready),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0 && MEM_TIMEOUT > 0;
`endif
  always_comb begin
    state_d = S_ERROR;
    case (state_q)
      S_RESET:     state_d = S_IF;
      S_IF:        state_d = S_ID;
      S_ID:
        case (op)
          OP_NOP:                          state_d = S_IF;
          OP_ADD, OP_ADDI, OP_LI, OP_SUB:  state_d = S_R_EXE;
          OP_LR:                           state_d = S_LR_ADDR;
          OP_SR:                           state_d = S_SR_ADDR;
          OP_BNEQ, OP_BEQ:                 state_d = S_BRANCH;
          OP_JMP:                          state_d = S_JUMP;
          default:                         state_d = S_ERROR;
        endcase
      S_R_EXE:     state_d = S_ALU_WB;
      S_LR_ADDR:   state_d = S_MEM_READ;
      S_SR_ADDR:   state_d = S_MEM_STORE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : timeout ? S_ERROR : S_MEM_READ;
      S_MEM_STORE: state_d = mem_ready ? S_IF : timeout ? S_ERROR : S_MEM_STORE;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_IF;
      default:     state_d = S_ERROR;
    endcase
  end
  always_ff @(posedge clk) state_q <= reset ? S_RESET : state_d;
  always_comb begin
    IR_Write           = 1'b0;
    MemToReg           = 1'b0;
    Mem_Read_not_Write = 1'b0;
    Mem_Select         = 1'b0;
    pc_write_enable    = 1'b0;
    alu_src_a          = 1'b0;
    RegWrite           = 1'b0;
    error              = 1'b0;
    PC_Source          = PC_ALU;
    alu_src_b          = SRC_B_REG;
    ALUop              = ALU_ADD;
    case (state_q)
      S_RESET: begin
        PC_Source          = PC_RESET_VEC;
        pc_write_enable    = 1'b1;
        Mem_Read_not_Write = 1'b1;
      end
      S_IF: begin
        IR_Write           = 1'b1;
        pc_write_enable    = 1'b1;
        alu_src_b          = SRC_B_PLUS_1;
        Mem_Read_not_Write = 1'b1;
      end
      S_ID: alu_src_b = SRC_B_IMM;
      S_R_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = (op == OP_ADDI || op == OP_LI) ? SRC_B_IMM : SRC_B_REG;
        ALUop     = op == OP_SUB ? ALU_SUB : op == OP_LI ? ALU_PASS_B : ALU_ADD;
      end
      S_LR_ADDR, S_SR_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        Mem_Select         = 1'b1;
        Mem_Read_not_Write = 1'b1;
      end
      S_MEM_STORE: Mem_Select = 1'b1;
      S_MEM_WB: begin
        Mem_Select = 1'b1;
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        ALUop           = ALU_SUB;
        pc_write_enable = take;
        PC_Source       = take ? PC_ALU_BUF : PC_ALU;
      end
      S_JUMP: begin
        pc_write_enable = 1'b1;
        PC_Source       = PC_JUMP;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl; timeout checks follow CTRL_MEM_TIMEOUT_EN
module tb_multicycle_ctrl;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, pc_write_enable;
  logic       alu_src_a, RegWrite, error;
  logic [1:0] PC_Source, alu_src_b, ALUop;
  logic [3:0] state_dbg;
  logic [12:0] ctl;
  int checks = 0, failures = 0;
  multicycle_ctrl #(.WIDTH_OPCODE(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IR_Write(IR_Write), .MemToReg(MemToReg), .Mem_Read_not_Write(Mem_Read_not_Write),
    .Mem_Select(Mem_Select), .pc_write_enable(pc_write_enable), .alu_src_a(alu_src_a),
    .RegWrite(RegWrite), .error(error), .PC_Source(PC_Source), .alu_src_b(alu_src_b),
    .ALUop(ALUop), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  assign ctl = {IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, pc_write_enable,
                alu_src_a, RegWrite, PC_Source, alu_src_b, ALUop};
  // expected control word: ir, mtr, rnw, msel, pwe, srca, rw, pcsrc, srcb, aluop
  function automatic logic [12:0] c(input bit ir, mtr, rnw, ms, pwe, sa, rw,
                                    input logic [1:0] pcs, sb, aop);
    return {ir, mtr, rnw, ms, pwe, sa, rw, pcs, sb, aop};
  endfunction
  localparam logic [12:0] C_RST = 13'b0010100_11_00_00;
  localparam logic [12:0] C_IF  = 13'b1010100_00_01_00;
  localparam logic [12:0] C_ID  = 13'b0000000_00_10_00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic ex(input string tag, input int st, input logic [12:0] cw, input bit err);
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(cw));
    chk({tag, ".err"}, 32'(error), 32'(err));
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(2);
    ex("rst", 0, C_RST, 0);
    reset = 1'b0; opcode = 4'd1;
    step(1); ex("add_if", 1, C_IF, 0);
    step(1); ex("add_id", 2, C_ID, 0);
    step(1); ex("add_exe", 3, c(0,0,0,0,0,1,0, 0,0,0), 0);
    step(1); ex("add_wb", 12, c(0,0,0,0,0,0,1, 0,0,0), 0);
    step(1); ex("add_if2", 1, C_IF, 0);
    opcode = 4'd3;
    step(2); ex("lr_addr", 4, c(0,0,0,0,0,1,0, 0,2,0), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1); ex($sformatf("lr_wait%0d", i), 9, c(0,0,1,1,0,0,0, 0,0,0), 0);
    end
    mem_ready = 1'b1;
    step(1); ex("lr_wb", 10, c(0,1,0,1,0,0,1, 0,0,0), 0);
    mem_ready = 1'b0;
    step(1); ex("lr_if", 1, C_IF, 0);
    opcode = 4'd5; zero = 1'b0;
    step(2); ex("bneq_z0", 6, c(0,0,0,0,1,1,0, 1,0,1), 0);
    step(1); ex("bneq_if", 1, C_IF, 0);
    opcode = 4'd8;
    step(2); ex("beq_z0", 6, c(0,0,0,0,0,1,0, 0,0,1), 0);
    zero = 1'b1;
    step(1); step(2); ex("beq_z1", 6, c(0,0,0,0,1,1,0, 1,0,1), 0);
    opcode = 4'd5;
    step(1); step(2); ex("bneq_z1", 6, c(0,0,0,0,0,1,0, 0,0,1), 0);
    zero = 1'b0; opcode = 4'd6;
    step(1); step(2); ex("li_exe", 3, c(0,0,0,0,0,1,0, 0,2,2), 0);
    opcode = 4'd7;
    step(2); step(2); ex("sub_exe", 3, c(0,0,0,0,0,1,0, 0,0,1), 0);
    opcode = 4'd2;
    step(2); step(2); ex("addi_exe", 3, c(0,0,0,0,0,1,0, 0,2,0), 0);
    opcode = 4'd9;
    step(2); step(2); ex("jmp", 7, c(0,0,0,0,1,0,0, 2,0,0), 0);
    opcode = 4'd0;
    step(1); step(2); ex("nop_if", 1, C_IF, 0);
    opcode = 4'd4;
    step(2); ex("sr_addr", 5, c(0,0,0,0,0,1,0, 0,2,0), 0);
    step(1); ex("sr_wait1", 11, c(0,0,0,1,0,0,0, 0,0,0), 0);
`ifdef CTRL_MEM_TIMEOUT_EN
    step(14); ex("sr_wait15", 11, c(0,0,0,1,0,0,0, 0,0,0), 0);
    step(1); ex("sr_timeout", 13, 13'd0, 1);
    opcode = 4'd1;
    step(3); ex("err_sticky", 13, 13'd0, 1);
    reset = 1'b1;
    step(1); ex("err_rst", 0, C_RST, 0);
    reset = 1'b0;
    step(1); opcode = 4'd3;
    step(3);
    step(14); ex("lr_wait15", 9, c(0,0,1,1,0,0,0, 0,0,0), 0);
    mem_ready = 1'b1;
    step(1); ex("ready_wins", 10, c(0,1,0,1,0,0,1, 0,0,0), 0);
    mem_ready = 1'b0;
    step(1);
`else
    step(40); ex("sr_wait41", 11, c(0,0,0,1,0,0,0, 0,0,0), 0);
    mem_ready = 1'b1;
    step(1); ex("sr_done", 1, C_IF, 0);
    mem_ready = 1'b0;
`endif
    ex("pre_undef", 1, C_IF, 0);
    opcode = 4'd12;
    step(2); ex("undef", 13, 13'd0, 1);
    reset = 1'b1;
    step(1); ex("undef_rst", 0, C_RST, 0);
    reset = 1'b0; opcode = 4'd3;
    step(4); ex("mid_wait", 9, c(0,0,1,1,0,0,0, 0,0,0), 0);
    reset = 1'b1; mem_ready = 1'b1;
    step(1); ex("rst_dom", 0, C_RST, 0);
    reset = 1'b0; mem_ready = 1'b0;
    step(1); ex("final_if", 1, C_IF, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_OPCODE, default 4, meaning opcode field width (>=4; upper bits must be 0 for defined opcodes).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning max data-memory wait cycles before error (1..255).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports opcode (in, WIDTH_OPCODE), zero (in, 1, ALU result==0) and mem_ready (in, 1, data memory access complete).
REQ-006 SHALL have 1-bit outputs IR_Write, MemToReg, Mem_Read_not_Write, Mem_Select, pc_write_enable, alu_src_a, RegWrite and error.
REQ-007 SHALL have 2-bit outputs PC_Source (0 ALU, 1 ALU_BUF, 2 JUMP, 3 RESET_VEC), alu_src_b (0 REG, 1 PLUS_1, 2 IMM) and ALUop (0 ADD, 1 SUB, 2 PASS_B).
REQ-008 SHALL have output state_dbg  4 bits  current state encoding.

Function
REQ-009 SHALL decode opcodes NOP=0, ADD=1, ADDI=2, LR=3, SR=4, BNEQ=5, LI=6, SUB=7, BEQ=8, JMP=9; all others undefined.
REQ-010 SHALL implement states RESET=0, IF=1, ID=2, R_EXE=3, LR_ADDR=4, SR_ADDR=5, BRANCH=6, JUMP=7, MEM_READ=9, MEM_WB=10, MEM_STORE=11, ALU_WB=12, ERROR=13; codes 8, 14, 15 transition to ERROR.
REQ-011 SHALL drive outputs combinationally from current state (plus opcode in R_EXE/BRANCH, zero in BRANCH, mem_ready in MEM_*); unlisted outputs are 0.
REQ-012 RESET: PC_Source=3, pc_write_enable=1, Mem_Read_not_Write=1; next IF.
REQ-013 IF: IR_Write=1, pc_write_enable=1, PC_Source=0, alu_src_b=1, ALUop=ADD, Mem_Read_not_Write=1; next ID (one cycle).
REQ-014 ID: alu_src_b=2, ALUop=ADD (branch target precompute); next IF (NOP), R_EXE (ADD/ADDI/LI/SUB), LR_ADDR, SR_ADDR, BRANCH (BNEQ/BEQ), JUMP, else ERROR.
REQ-015 R_EXE: alu_src_a=1; ADD: src_b=0, ADD; SUB: src_b=0, SUB; ADDI: src_b=2, ADD; LI: src_b=2, PASS_B; next ALU_WB.
REQ-016 ALU_WB: RegWrite=1, MemToReg=0; next IF.
REQ-017 LR_ADDR/SR_ADDR: alu_src_a=1, alu_src_b=2, ADD; next MEM_READ/MEM_STORE.
REQ-018 MEM_READ: Mem_Select=1, Mem_Read_not_Write=1; holds while mem_ready=0; to MEM_WB the cycle after mem_ready=1.
REQ-019 MEM_STORE: Mem_Select=1, Mem_Read_not_Write=0; holds while mem_ready=0; to IF the cycle after mem_ready=1.
REQ-020 MEM_WB: Mem_Select=1, RegWrite=1, MemToReg=1; next IF.
REQ-021 BRANCH: alu_src_a=1, src_b=0, SUB; take = (BNEQ & !zero) | (BEQ & zero); if taken pc_write_enable=1, PC_Source=1; next IF.
REQ-022 JUMP: pc_write_enable=1, PC_Source=2; next IF.
REQ-023 ERROR: error=1, all other outputs 0; sticky until reset.
REQ-024 Wait counter SHALL clear on entry to MEM_READ/MEM_STORE, increment each waiting cycle, saturate at 8 bits.

Reset
REQ-025 reset=1 at any edge, including mid-wait or in ERROR, SHALL force state RESET and clear the wait counter next cycle; reset dominates mem_ready.
REQ-026 While in RESET, outputs SHALL equal REQ-012 values; error=0.

Configuration
REQ-027 With CTRL_MEM_TIMEOUT_EN defined, MEM_READ/MEM_STORE SHALL go to ERROR when counter reaches MEM_TIMEOUT with mem_ready=0; mem_ready=1 in that same cycle wins.
REQ-028 Without CTRL_MEM_TIMEOUT_EN, the counter SHALL be absent and memory states wait indefinitely; ERROR reachable only via undefined opcode/state.

Structure
REQ-029 Opcode, state, ALUop, PC_Source and alu_src_b encodings SHALL live in shared package ctrl_pkg.
REQ-030 Wait counter and timeout compare SHALL be sub-module mem_wait_timer, instantiated only under CTRL_MEM_TIMEOUT_EN.

Verification
REQ-031 reset 2 cycles, opcode=1 -> RESET,IF,ID,R_EXE(src_b=0,ADD),ALU_WB(RegWrite=1),IF.
REQ-032 opcode=3, mem_ready low 3 cycles -> MEM_READ held 4 cycles, then MEM_WB with MemToReg=1, RegWrite=1.
REQ-033 opcode=5 zero=0 -> BRANCH pc_write_enable=1, PC_Source=1; opcode=8 zero=0 -> pc_write_enable=0.
REQ-034 opcode=4, mem_ready=0 forever, macro on, MEM_TIMEOUT=15 -> ERROR after 15 wait cycles, error=1 until reset.
REQ-035 opcode=12 -> ERROR; reset asserted -> RESET next cycle, error=0.
REQ-036 opcode=6 -> R_EXE ALUop=2, alu_src_b=2; opcode=9 -> JUMP PC_Source=2, pc_write_enable=1.
